// File: rtl/imem_boot_ctrl.sv
// Boot-load controller for the instruction memory.
// Parses a framed byte stream (sync, length, little-endian words, checksum), writes each
// word into instr_mem and releases the core (cpu_run) once a frame checks out.
module imem_boot_ctrl #(
    parameter int unsigned ADDR_W         = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              load_busy,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLen0  = 3'd1;
    localparam logic [2:0] StLen1  = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StCsum  = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;
    localparam logic [2:0] StError = 3'd6;

    localparam logic [16:0]     MaxLen   = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] WordsMax = (ADDR_W + 1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] WordOne  = (ADDR_W + 1)'(1);
    localparam logic [31:0]     TmoLast  = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       buf_q, buf_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              frame_active;
    logic [16:0]       len_full;

    assign frame_active = (state_q == StLen0) || (state_q == StLen1) ||
                          (state_q == StData) || (state_q == StCsum);
    assign len_full     = {1'b0, rx_byte, len_lo_q};

    // Next-state: byte parsing, word assembly, write pulse and inter-byte timeout
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        words_d    = words_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        csum_d     = csum_q;
        tmo_d      = tmo_q;

        // The word count advances in the cycle its write pulse is on the port
        if (we_q && (words_q != WordsMax)) begin
            words_d = words_q + WordOne;
        end

        if (frame_active) begin
            tmo_d = rx_dv ? 32'd0 : tmo_q + 32'd1;
        end

        if (rx_dv) begin
            unique case (state_q)
                StIdle, StDone, StError: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d    = StLen0;
                        words_d    = '0;
                        csum_d     = 8'h00;
                        byte_cnt_d = 2'd0;
                        tmo_d      = 32'd0;
                    end
                end
                StLen0: begin
                    len_lo_d = rx_byte;
                    csum_d   = csum_q ^ rx_byte;
                    state_d  = StLen1;
                end
                StLen1: begin
                    csum_d = csum_q ^ rx_byte;
                    if (len_full > MaxLen) begin
                        state_d = StError;
                    end else begin
                        len_d   = len_full[ADDR_W:0];
                        state_d = (len_full == 17'd0) ? StCsum : StData;
                    end
                end
                StData: begin
                    csum_d     = csum_q ^ rx_byte;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: buf_d[7:0]   = rx_byte;
                        2'd1: buf_d[15:8]  = rx_byte;
                        2'd2: buf_d[23:16] = rx_byte;
                        2'd3: begin
                            wdata_d = {rx_byte, buf_q};
                            we_d    = 1'b1;
                            if ((words_d + WordOne) == len_q) begin
                                state_d = StCsum;
                            end
                        end
                        default: ;
                    endcase
                end
                StCsum: begin
                    state_d = (rx_byte == csum_q) ? StDone : StError;
                end
                default: state_d = StIdle;
            endcase
        end else if (frame_active && (tmo_q == TmoLast)) begin
            state_d = StError;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len_lo_q   <= 8'h00;
            len_q      <= '0;
            words_q    <= '0;
            byte_cnt_q <= 2'd0;
            buf_q      <= 24'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            csum_q     <= 8'h00;
            tmo_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            words_q    <= words_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
        end
    end

    assign cpu_run      = (state_q == StDone);
    assign load_error   = (state_q == StError);
    assign load_busy    = frame_active;
    // Gate keeps the loader from ever writing over a running image
    assign mem_we       = we_q & ~cpu_run;
    assign mem_addr     = cpu_run ? cpu_addr : words_q[ADDR_W-1:0];
    assign mem_wdata    = wdata_q;
    assign words_loaded = words_q;

endmodule
